// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - Op encodings as driven on the Op port
//   - FSM state enum
//   - default operand width and iteration count
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = MDU_WIDTH;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: combinational sign handling around the unsigned core.
//   Operand side (used when an operation is latched):
//     i_rs, i_rt       raw register-file words
//     i_signed         1 for MULT/DIV, 0 for MULTU/DIVU
//     o_sign_a/b       operand sign flags (forced 0 for unsigned ops)
//     o_mag_a/b        operand magnitudes (-2^(W-1) maps to 2^(W-1))
//   Result side (used in FIXUP):
//     i_prod/i_neg_prod -> o_prod       2W-bit product, optionally negated
//     i_quo/i_neg_quo   -> o_quo        quotient, optionally negated
//     i_rem/i_neg_rem   -> o_rem        remainder, optionally negated
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_rs,
  input  logic [WIDTH-1:0]   i_rt,
  input  logic               i_signed,
  output logic               o_sign_a,
  output logic               o_sign_b,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic               i_neg_prod,
  output logic [2*WIDTH-1:0] o_prod,
  input  logic [WIDTH-1:0]   i_quo,
  input  logic               i_neg_quo,
  output logic [WIDTH-1:0]   o_quo,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic               i_neg_rem,
  output logic [WIDTH-1:0]   o_rem
);

  assign o_sign_a = i_signed & i_rs[WIDTH-1];
  assign o_sign_b = i_signed & i_rt[WIDTH-1];

  // Two's-complement negation of the most negative value wraps to itself,
  // which read as unsigned is exactly its magnitude.
  assign o_mag_a = o_sign_a ? (~i_rs + 1'b1) : i_rs;
  assign o_mag_b = o_sign_b ? (~i_rt + 1'b1) : i_rt;

  assign o_prod = i_neg_prod ? (~i_prod + 1'b1) : i_prod;
  assign o_quo  = i_neg_quo  ? (~i_quo  + 1'b1) : i_quo;
  assign o_rem  = i_neg_rem  ? (~i_rem  + 1'b1) : i_rem;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: radix-2 iterative multiply/divide with HI/LO registers.
//   CLK, RST           clock, asynchronous active-high reset
//   Start, Op          launch MULT/MULTU/DIV/DIVU (sampled in IDLE only)
//   Rs_data, Rt_data   operands A/dividend and B/divisor
//   Mthi, Mtlo         write Rs_data into HI/LO (IDLE only)
//   Busy               operation in progress
//   Done               one-cycle pulse after HI/LO take a result
//   Div_by_zero        qualifies Done for divides with a zero divisor
//   HI, LO             architectural result registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  input  logic             Mthi,
  input  logic             Mtlo,
  output logic             Busy,
  output logic             Done,
  output logic             Div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  mdu_state_t r_state, w_state_next;

  logic               r_is_div;
  logic               r_dbz_pend;
  logic               r_sign_a, r_sign_b;
  logic [WIDTH-1:0]   r_mag_a, r_mag_b;
  // Multiply: {partial product high, multiplier remnant}.
  // Divide:   low half is the dividend shifting into the quotient.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_dbz;

  logic               w_is_div, w_start_dbz;
  logic               w_sign_a, w_sign_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift, w_div_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  assign w_is_div    = Op[1];
  assign w_start_dbz = w_is_div && (Rt_data == '0);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_rs       (Rs_data),
    .i_rt       (Rt_data),
    .i_signed   (~Op[0]),
    .o_sign_a   (w_sign_a),
    .o_sign_b   (w_sign_b),
    .o_mag_a    (w_mag_a),
    .o_mag_b    (w_mag_b),
    .i_prod     (r_acc),
    .i_neg_prod (r_sign_a ^ r_sign_b),
    .o_prod     (w_prod_fix),
    .i_quo      (r_acc[WIDTH-1:0]),
    .i_neg_quo  (r_sign_a ^ r_sign_b),
    .o_quo      (w_quo_fix),
    .i_rem      (r_rem),
    .i_neg_rem  (r_sign_a),
    .o_rem      (w_rem_fix)
  );

  // Shift-add step: add multiplicand to the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: shift in the next dividend bit and try the subtract.
  // Since the remainder is always below the divisor, a non-negative
  // difference always fits in WIDTH bits, so its MSB is the borrow.
  assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_qbit      = ~w_div_diff[WIDTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          w_state_next = w_start_dbz ? S_FIXUP : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_state_next = S_FIXUP;
        end
      end
      S_FIXUP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_is_div   <= 1'b0;
      r_dbz_pend <= 1'b0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Mthi) r_hi <= Rs_data;
          if (Mtlo) r_lo <= Rs_data;
          if (Start) begin
            r_is_div   <= w_is_div;
            r_dbz_pend <= w_start_dbz;
            r_sign_a   <= w_sign_a;
            r_sign_b   <= w_sign_b;
            // A zero divide returns the raw dividend in HI, so keep it
            // unmodified instead of its magnitude.
            r_mag_a    <= w_start_dbz ? Rs_data : w_mag_a;
            r_mag_b    <= w_mag_b;
            r_acc      <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a}
                                   : {{WIDTH{1'b0}}, w_mag_b};
            r_rem      <= '0;
            r_cnt      <= '0;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_is_div) begin
            r_rem            <= w_qbit ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_qbit};
          end else begin
            r_acc <= w_mul_next;
          end
        end
        S_FIXUP: begin
          r_done <= 1'b1;
          if (r_dbz_pend) begin
            r_hi  <= r_mag_a;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign Done        = r_done;
  assign Div_by_zero = r_dbz;
  assign HI          = r_hi;
  assign LO          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit. Expected HI/LO/flag
// are queued when an operation is launched and compared when Done pulses.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] Rs_data = '0;
  logic [31:0] Rt_data = '0;
  logic        Mthi = 1'b0;
  logic        Mtlo = 1'b0;
  logic        Busy, Done, Div_by_zero;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;
  exp_t sb[$];

  mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .Mthi(Mthi), .Mtlo(Mtlo),
    .Busy(Busy), .Done(Done), .Div_by_zero(Div_by_zero), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Scoreboard side: every Done pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {31'd0, Done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_hi", HI, e.hi);
        check("res_lo", LO, e.lo);
        check("res_dbz", {31'd0, Div_by_zero}, {31'd0, e.dbz});
      end
    end
  end

  // Launch one op, then measure Done latency and Busy duration.
  // With disturb set, Start (other operands) and Mthi are pulsed mid-run.
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dbz, input int exp_lat, input bit disturb);
    int lat;
    int busy_cnt;
    exp_t e;
    @(negedge CLK);
    Start = 1'b1; Op = op; Rs_data = rs; Rt_data = rt;
    e.hi = exp_hi; e.lo = exp_lo; e.dbz = exp_dbz;
    sb.push_back(e);
    @(posedge CLK); #1;
    Start = 1'b0;
    busy_cnt = (Busy === 1'b1) ? 1 : 0;
    lat = 0;
    while (Done !== 1'b1 && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (disturb && lat == 5) begin
        Start = 1'b1; Op = OP_DIV; Rs_data = 32'hDEADBEEF; Rt_data = 32'd3; Mthi = 1'b1;
      end else begin
        Start = 1'b0; Mthi = 1'b0;
      end
      if (Busy === 1'b1) busy_cnt++;
    end
    check("done_latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
  endtask

  initial begin
    int done_seen;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_dbz", {31'd0, Div_by_zero}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_op(OP_MULT,  32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
    run_op(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33, 1'b0);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_op(OP_DIV,   32'd7,       32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 1'b0);
    run_op(OP_DIVU,  32'd100,     32'd7,       32'd2,        32'd14,       1'b0, 33, 1'b0);
    run_op(OP_DIVU,  32'hFFFFFFFF, 32'h10,      32'h0000000F, 32'h0FFFFFFF, 1'b0, 33, 1'b0);
    run_op(OP_DIVU,  32'h1234,    32'd0,       32'h00001234, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1,  1'b0);
    // Mid-run Start/Mthi must be ignored
    run_op(OP_MULTU, 32'h12345678, 32'h100,     32'h00000012, 32'h34567800, 1'b0, 33, 1'b1);

    // MTLO after Done
    @(negedge CLK);
    Mtlo = 1'b1; Rs_data = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    Mtlo = 1'b0;
    check("mtlo_lo", LO, 32'hA5A5A5A5);
    check("mtlo_hi_kept", HI, 32'h00000012);

    // Reset in the middle of a DIV
    @(negedge CLK);
    Start = 1'b1; Op = OP_DIV; Rs_data = 32'd1000; Rt_data = 32'd3;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (Done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);

    run_op(OP_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 1'b0);

    repeat (3) @(posedge CLK);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle integer multiply/divide unit for the 32-bit MIPS datapath. It sits directly downstream of the register file and consumes the two read-port words (rs, rt) for MULT, MULTU, DIV and DIVU. It holds the architectural HI/LO registers that MFHI/MFLO read and MTHI/MTLO write. It uses a radix-2 iterative algorithm with a start/busy/done handshake, so control stalls on Busy instead of closing timing on a single-cycle 32x32 array.

## Interface
Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- ITER, WIDTH, iteration cycles per operation.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Start  input  1  request operation; sampled only in IDLE.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Rs_data  input  WIDTH  operand A / dividend, from register file port 1.
- Rt_data  input  WIDTH  operand B / divisor, from register file port 2.
- Mthi  input  1  write Rs_data into HI (MTHI).
- Mtlo  input  1  write Rs_data into LO (MTLO).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- Div_by_zero  output  1  qualifies Done; high for divides with Rt_data==0.
- HI  output  WIDTH  HI register (product high word / remainder).
- LO  output  WIDTH  LO register (product low word / quotient).

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE & Start: latch the operation and the operand sign flags. Signed ops use signed flags; unsigned ops use zero flags. Latch operand magnitudes (two's-complement absolute value for signed ops; -2^31 maps to unsigned 0x80000000). Clear the counter and go to CALC.
- IDLE & Start & divide & Rt_data==0: go straight to FIXUP; no CALC.
- CALC, multiply: shift-add on magnitudes into a 2·WIDTH accumulator, one multiplier bit per cycle.
- CALC, divide: restoring division, one quotient bit per cycle; the remainder is WIDTH+1 bits internally.
- CALC: after counter reaches ITER-1, go to FIXUP.
- FIXUP, signed multiply: negate the 64-bit product if the signs differ.
- FIXUP, signed divide: quotient sign = sign(A)^sign(B); remainder sign = sign(A).
- FIXUP writes the result: multiply gives HI=product[63:32], LO=product[31:0]; divide gives HI=remainder, LO=quotient. Then go to IDLE.
- Divide by zero result: HI=Rs_data (latched), LO=all ones, Div_by_zero=1 with Done.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0; no flag.
- Mthi/Mtlo: in IDLE, write HI/LO at the next edge. Ignored while Busy. If asserted together with Start, the MT write takes effect, and the result overwrites it at completion.
- Start while Busy: ignored; no queuing.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Div_by_zero=0, HI=0, LO=0, counter=0.
- Start sampled at edge E0. Busy goes high after E0.
- CALC iterations occur at E1..E32. FIXUP is the cycle after E32, and HI/LO update at E33.
- After E33: Busy=0, Done=1 and Div_by_zero valid for exactly one cycle.
- Result latency is 33 cycles from the Start edge. A new Start is accepted in the Done cycle.
- Divide by zero: FIXUP after E0; HI/LO update and Done at E1.
- HI/LO are registered and stable except at the Done edge or an MT write.
- RST mid-operation aborts immediately. All outputs return to reset values and no partial result is written.

## Structure
- Package mdu_pkg: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum, default WIDTH/ITER constants.
- Sub-module mdu_sign_fix (combinational):
  - operand magnitude extraction;
  - final 64-bit product negation or quotient/remainder negation.
- Used at latch time and in FIXUP; keeps the FSM/datapath file lean.

## Test plan
- MULT Rs=0xFFFFFFFD (-3), Rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done exactly 33 cycles after the Start edge; Busy high for 33 cycles.
- MULTU Rs=Rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; same input as MULT -> HI=0, LO=1.
- DIV Rs=0xFFFFFFF9 (-7), Rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 100/7 -> LO=14, HI=2.
- DIVU Rs=0x1234, Rt=0 -> Done one cycle after Start, Div_by_zero=1, HI=0x1234, LO=0xFFFFFFFF.
- During MULTU, pulse Start (other operands) and Mthi at cycle 5 -> both ignored, original result delivered. After Done, Mtlo with Rs=0xA5A5A5A5 -> LO=0xA5A5A5A5 next cycle.
- Assert RST at cycle 10 of a DIV -> Busy, Done, HI, LO all 0 immediately; no Done ever pulses; a subsequent MULT 6x7 gives LO=42, HI=0.
